// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;

    // Status decode and request acceptance from the registered count.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty_s  = (count_q == {CW{1'b0}});
        rd_acc_s = rd_en & ~empty_s;
        // A full FIFO still takes a write when a read frees the slot this cycle.
        wr_acc_s = wr_en & (~full_s | rd_acc_s);
    end

    // Next-state computation for pointers, count, read data and error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = wr_en & ~wr_acc_s;
        underflow_d = rd_en & ~rd_acc_s;
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            dout_q      <= {DATA_WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clock) begin
        if (rst && wr_acc_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign count        = count_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue scoreboard holds the expected
// contents and every cycle's outputs are compared against it.
module tb_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic          clock;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ov;
    logic          exp_uf;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AFL),
        .AE_LEVEL   (AEL)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: update the scoreboard, apply the edge, then compare.
    task automatic step(input logic rs, input logic w, input logic r, input logic [DW-1:0] d);
        bit racc;
        bit wacc;
        int n;
        rst   = rs;
        wr_en = w;
        rd_en = r;
        din   = d;
        if (!rs) begin
            sb_q.delete();
            exp_dout = '0;
            exp_ov   = 1'b0;
            exp_uf   = 1'b0;
        end else begin
            racc = r && (sb_q.size() > 0);
            wacc = w && ((sb_q.size() < DEPTH) || racc);
            if (racc) exp_dout = sb_q.pop_front();
            if (wacc) sb_q.push_back(d);
            exp_ov = w && !wacc;
            exp_uf = r && !racc;
        end
        @(posedge clock);
        #1;
        n = sb_q.size();
        check_val("dout",         32'(dout),         32'(exp_dout));
        check_val("count",        32'(count),        32'(n));
        check_val("full",         32'(full),         32'(n == DEPTH));
        check_val("empty",        32'(empty),        32'(n == 0));
        check_val("almost_full",  32'(almost_full),  32'(n >= AFL));
        check_val("almost_empty", 32'(almost_empty), 32'(n <= AEL));
        check_val("overflow",     32'(overflow),     32'(exp_ov));
        check_val("underflow",    32'(underflow),    32'(exp_uf));
    endtask

    task automatic wr_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom));
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom));
    endtask

    task automatic both_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, DW'($urandom));
    endtask

    initial begin
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        exp_dout = '0;
        exp_ov   = 1'b0;
        exp_uf   = 1'b0;

        // Reset held with random requests
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom), 1'($urandom), DW'($urandom));

        // Fill past full, then drain past empty
        wr_n(25);
        rd_n(20);

        // Wrap-around
        wr_n(10);
        rd_n(10);
        wr_n(16);
        rd_n(16);

        // Simultaneous at mid level, at full, at empty
        wr_n(8);
        both_n(5);
        wr_n(8);
        both_n(1);
        rd_n(16);
        both_n(1);

        // Reset mid-operation with count 7
        wr_n(6);
        step(1'b0, 1'b1, 1'b1, DW'($urandom));
        wr_n(2);
        rd_n(3);

        // Random traffic
        for (int i = 0; i < 300; i++) step(1'b1, 1'($urandom), 1'($urandom), DW'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer for 16-bit data words (width and depth parameterised). It decouples a producer and a consumer that share one clock domain, with registered read data, full/empty status, occupancy count, almost-full/almost-empty thresholds and overflow/underflow error pulses. Used as a generic rate-matching buffer between datapath stages.

## Interface
- DATA_WIDTH, 16, width of din/dout.
- DEPTH, 16, number of storage words; power of two, minimum 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- clock  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Synchronous, active-low reset; sampled on rising clock edge.
- wr_en  input  1  Write request; din is stored when accepted.
- din  input  DATA_WIDTH  Write data.
- rd_en  input  1  Read request; head word is output when accepted.
- dout  output  DATA_WIDTH  Registered read data.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  clog2(DEPTH)+1  Current occupancy, 0..DEPTH.
- overflow  output  1  One-cycle pulse: write requested while full and not accepted.
- underflow  output  1  One-cycle pulse: read requested while empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array; write pointer and read pointer, each clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy.
- Write accepted when wr_en=1 and (full=0, or full=1 with a read accepted in the same cycle). Accepted write stores din at wr_ptr, wr_ptr increments.
- Read accepted when rd_en=1 and empty=0. Accepted read loads mem[rd_ptr] into dout, rd_ptr increments.
- dout holds its last value when no read is accepted.
- count: +1 on write-only, -1 on read-only, unchanged when both or neither accepted.
- full = (count == DEPTH); empty = (count == 0); almost flags from count; all flags are combinational decodes of the count register (i.e. registered-state derived, glitch-free per cycle).
- Simultaneous wr_en and rd_en:
  - not empty, not full: both accepted, count unchanged.
  - full: read accepted, write accepted (slot freed), count stays DEPTH, no overflow.
  - empty: write accepted, read rejected (no fall-through), underflow pulses, count becomes 1.
- Rejected write (full, no accepted read): data discarded, memory and pointers unchanged, overflow=1 for the following cycle.
- Rejected read (empty): pointers and dout unchanged, underflow=1 for the following cycle.
- Reset (rst=0 at clock edge): pointers=0, count=0, dout=0, overflow=0, underflow=0; thus empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not cleared. Reset overrides any concurrent wr_en/rd_en; reset mid-operation discards all stored words.

## Timing
- All outputs change only after a rising clock edge.
- Write latency: word written at edge N is readable (empty=0) after edge N; a read requested in cycle N+1 presents it on dout after edge N+1.
- Read latency: one cycle from accepted rd_en to valid dout.
- Flags, count update in the same edge as the accepted operation.
- overflow/underflow are high for exactly one cycle per rejected request; back-to-back rejected requests keep them high.
- Pointer wrap from DEPTH-1 to 0 has no bubble.

## Test plan
- Reset: hold rst=0 for 10 cycles with random wr_en/rd_en -> empty=1, full=0, count=0, dout=0, no error pulses.
- Fill/overflow: after reset, wr_en=1 for 25 consecutive cycles with random din -> count reaches 16 after 16th write, full=1, almost_full=1 from count 14, overflow high for the last 9 cycles, stored data = first 16 din values.
- Drain/underflow: then rd_en=1 for 20 cycles -> dout yields the 16 stored words in order one cycle after each read, empty=1 after 16th read, underflow high for last 4 cycles, dout holds the 16th word.
- Wrap-around: write 10, read 10, write 16, read 16 -> data order preserved across pointer wrap, full/empty correct.
- Simultaneous ops: at count=8 assert both for 5 cycles -> count stays 8, output order preserved; at full assert both -> count 16, no overflow; at empty assert both -> count 1, underflow pulse, dout unchanged.
- Reset mid-operation: with count=7, drive rst=0 one cycle -> count=0, empty=1, dout=0; subsequent write/read returns new data only.
